// File: rtl/gray_decode_arbiter.sv
// Round-robin arbiter that shares one Gray-to-binary decoder among NUM_REQ
// valid/ready requesters and registers the result together with the winner's ID.
`timescale 1ns/1ps
module gray_decode_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_gray,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_bin,
  output logic [ID_W-1:0]               out_id,
  output logic [15:0]                   done_cnt
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_bin_q, out_bin_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [15:0]           done_cnt_q, done_cnt_d;

  logic                  can_accept;
  logic                  accept;
  logic                  drain;
  logic                  win_found;
  logic [ID_W-1:0]       win_idx;
  logic [ID_W-1:0]       scan_idx;
  logic [ID_W-1:0]       ptr_inc;
  logic [DATA_WIDTH-1:0] sel_gray;
  logic [DATA_WIDTH-1:0] sel_bin;

  assign can_accept = !out_valid_q || out_ready;
  assign drain      = out_valid_q && out_ready;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + ID_W'(1);
    end
  end

  always_comb begin
    req_ready = '0;
    accept    = resetn && can_accept && win_found;
    if (accept) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_gray = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_idx) begin
        sel_gray = req_gray[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Prefix XOR from the MSB down: bin[k] = ^gray[DATA_WIDTH-1:k].
  always_comb begin
    sel_bin = sel_gray;
    for (int k = DATA_WIDTH - 2; k >= 0; k--) begin
      sel_bin[k] = sel_bin[k+1] ^ sel_gray[k];
    end
  end

  assign ptr_inc = (win_idx == LAST_IDX) ? '0 : win_idx + ID_W'(1);

  always_comb begin
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    done_cnt_d  = done_cnt_q;
    if (drain) begin
      done_cnt_d  = done_cnt_q + 16'd1;
      out_valid_d = 1'b0;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_bin_d   = sel_bin;
      out_id_d    = win_idx;
      rr_ptr_d    = ptr_inc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= '0;
      done_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_id    = out_id_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// Directed + randomized bench for gray_decode_arbiter (DATA_WIDTH=4, NUM_REQ=4)
// against a behavioural model of the arbitration and decode rules.
`timescale 1ns/1ps
module tb_gray_decode_arbiter;

  localparam int DW = 4;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NR-1:0] req_valid;
  logic [DW-1:0] g [NR];
  logic [NR*DW-1:0] req_gray;
  logic [NR-1:0] req_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_bin;
  logic [1:0]    out_id;
  logic [15:0]   done_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic          m_valid;
  logic [DW-1:0] m_bin;
  int            m_id;
  int            m_ptr;
  logic [15:0]   m_cnt;
  logic [NR-1:0] last_rdy;

  assign req_gray = {g[3], g[2], g[1], g[0]};

  always #5 clk = ~clk;

  gray_decode_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_gray  (req_gray),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_id    (out_id),
    .done_cnt  (done_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] gdec(input logic [DW-1:0] gv);
    logic [DW-1:0] b;
    b = '0;
    for (int s = 0; s < DW; s++) b ^= gv >> s;
    return b;
  endfunction

  function automatic logic [NR-1:0] model_ready();
    logic [NR-1:0] r;
    r = '0;
    if (resetn && !(m_valid && !out_ready)) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (r == 0 && req_valid[idx]) r[idx] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_bin   = '0;
    m_id    = 0;
    m_ptr   = 0;
    m_cnt   = '0;
  endtask

  task automatic model_edge(input logic [NR-1:0] er);
    if (m_valid && out_ready) begin
      m_cnt++;
      m_valid = 1'b0;
    end
    for (int i = 0; i < NR; i++) begin
      if (er[i]) begin
        m_valid = 1'b1;
        m_bin   = gdec(g[i]);
        m_id    = i;
        m_ptr   = (i + 1) % NR;
      end
    end
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic step(input string tag, input bit do_chk);
    logic [NR-1:0] er;
    #1;
    er = model_ready();
    if (do_chk) chk({tag, "_rdy"}, 32'(req_ready), 32'(er));
    @(posedge clk);
    model_edge(er);
    last_rdy = er;
    #1;
    if (do_chk) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, "_bin"},   32'(out_bin),   32'(m_bin));
      chk({tag, "_id"},    32'(out_id),    32'(m_id));
      chk({tag, "_cnt"},   32'(done_cnt),  32'(m_cnt));
    end
  endtask

  task automatic pulse_reset();
    #2 resetn = 1'b0;
    #2 resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    int exp_ids [5];
    int exp_bins[5];
    logic [DW-1:0] out_bin_hold;
    logic [NR-1:0] hold_v;

    exp_ids  = '{0, 1, 2, 3, 0};
    exp_bins = '{0, 4, 2, 15, 0};
    last_rdy = '0;
    model_reset();

    // reset held with random inputs
    resetn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = NR'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < NR; i++) g[i] = DW'($urandom_range(0, 15));
      @(posedge clk); #1;
      chk("rst_rdy",   32'(req_ready), 32'(0));
      chk("rst_valid", 32'(out_valid), 32'(0));
      chk("rst_bin",   32'(out_bin),   32'(0));
      chk("rst_id",    32'(out_id),    32'(0));
      chk("rst_cnt",   32'(done_cnt),  32'(0));
    end

    // first grant right after reset release
    resetn    = 1'b1;
    req_valid = 4'b0001;
    g[0]      = 4'b1000;
    out_ready = 1'b1;
    step("rst_first", 1);
    chk("rst_first_bin_k", 32'(out_bin), 32'hF);
    chk("rst_first_id_k",  32'(out_id),  32'(0));

    // round robin with all requesters valid
    pulse_reset();
    req_valid = 4'b1111;
    g[0] = 4'b0000; g[1] = 4'b0110; g[2] = 4'b0011; g[3] = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      step("rr", 1);
      chk("rr_id_k",  32'(out_id),  32'(exp_ids[k]));
      chk("rr_bin_k", 32'(out_bin), 32'(exp_bins[k]));
    end
    req_valid = 4'b0000;
    step("rr_tail", 1);
    chk("rr_cnt_k", 32'(done_cnt), 32'(5));

    // backpressure: rr_ptr is 1 here
    req_valid = 4'b0001;
    step("bp_load", 1);
    out_bin_hold = out_bin;
    req_valid = 4'b0110;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step("bp_stall", 1);
      chk("bp_stall_bin_k", 32'(out_bin), 32'(out_bin_hold));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy_k", 32'(req_ready), 32'(4'b0010));
    step("bp_release", 1);
    chk("bp_release_id_k", 32'(out_id), 32'(1));

    // skip / wrap: make rr_ptr = 3 then requesters 0 and 2 only
    req_valid = 4'b0100;
    step("sw_setup", 1);
    req_valid = 4'b0101;
    step("sw_a", 1); chk("sw_a_id_k", 32'(out_id), 32'(0));
    step("sw_b", 1); chk("sw_b_id_k", 32'(out_id), 32'(2));
    step("sw_c", 1); chk("sw_c_id_k", 32'(out_id), 32'(0));

    // exhaustive decode via requester 2
    req_valid = 4'b0100;
    for (int v = 0; v < 16; v++) begin
      g[2] = DW'(v ^ (v >> 1));
      step("dec", 1);
      chk("dec_bin_k", 32'(out_bin), 32'(v));
      chk("dec_id_k",  32'(out_id),  32'(2));
    end

    // randomized traffic; waiting requesters hold their value
    hold_v = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!hold_v[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          g[i]         = DW'($urandom_range(0, 15));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand", 1);
      hold_v = req_valid & ~last_rdy;
    end

    // asynchronous reset while a result is pending
    req_valid = 4'b0001;
    out_ready = 1'b1;
    step("mid_load", 1);
    out_ready = 1'b0;
    req_valid = 4'b0000;
    #2 resetn = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid), 32'(0));
    chk("mid_cnt",   32'(done_cnt),  32'(0));
    chk("mid_rdy",   32'(req_ready), 32'(0));
    #1 resetn = 1'b1;
    model_reset();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    step("mid_ptr", 1);
    chk("mid_ptr_id_k", 32'(out_id), 32'(0));

    // done_cnt wrap
    pulse_reset();
    req_valid = 4'b0001;
    g[0]      = 4'b0101;
    out_ready = 1'b1;
    for (int c = 0; c < 65536; c++) step("wrap_fill", 0);
    chk("wrap_full", 32'(done_cnt), 32'hFFFF);
    chk("wrap_full_model", 32'(done_cnt), 32'(m_cnt));
    step("wrap_over", 1);
    chk("wrap_zero", 32'(done_cnt), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
